// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation encodings, FSM state encoding and default geometry.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Bit 1 of the op code separates the divide family from the multiply family.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift/add-subtract datapath.
// Accumulator layout (2*WIDTH+1 bits):
//   multiply: {spare, product_hi, multiplier_remaining}; right-shift-add.
//   divide  : {remainder(WIDTH+1), dividend_remaining/quotient}; restoring
//             shift-subtract, the extra remainder bit holds the carry.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH:0]   acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0] mul_sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] rem_nx_s;
  logic           unused_top_s;

  // The spare top bit is always zero on entry to an iteration.
  assign unused_top_s = acc_i[2*WIDTH];

  // Single combinational iteration for either multiply or divide.
  always_comb begin
    acc_o     = {(2*WIDTH+1){1'b0}};
    q_bit_o   = 1'b0;
    mul_sum_s = {(WIDTH+1){1'b0}};
    rem_sh_s  = {(WIDTH+1){1'b0}};
    rem_nx_s  = {(WIDTH+1){1'b0}};
    if (is_div_i) begin
      // Shift the next dividend bit into the remainder, then try to subtract.
      rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
      if (rem_sh_s >= {1'b0, operand_i}) begin
        rem_nx_s = rem_sh_s - {1'b0, operand_i};
        q_bit_o  = 1'b1;
      end else begin
        rem_nx_s = rem_sh_s;
        q_bit_o  = 1'b0;
      end
      acc_o = {rem_nx_s, acc_i[WIDTH-2:0], q_bit_o};
    end else begin
      // Add the multiplicand when the current multiplier bit is set, then shift.
      if (acc_i[0]) begin
        mul_sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
      end else begin
        mul_sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      end
      acc_o = {1'b0, mul_sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit writing architectural HI/LO.
// Sequence: IDLE -> RUN (WIDTH iterations) -> FIX (sign fix + writeback)
// -> DONE (one-cycle done pulse) -> IDLE. Divide by zero goes IDLE -> DONE.
// Build option: define MULDIV_SIGNED_EN to enable signed MULT/DIV; without
// it op[0] is ignored and FIX is a pure writeback cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic [2*WIDTH:0]   step_acc_s;
  logic               step_qbit_unused_s;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc_s),
    .q_bit_o   (step_qbit_unused_s)
  );

`ifdef MULDIV_SIGNED_EN
  logic               sa_s;
  logic               sb_s;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] prod_neg_s;

  // Operand magnitudes: two's-complement absolute value for signed ops.
  always_comb begin
    sa_s = op[0] & operand_a[WIDTH-1];
    sb_s = op[0] & operand_b[WIDTH-1];
    if (sa_s) begin
      mag_a_s = ~operand_a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_a_s = operand_a;
    end
    if (sb_s) begin
      mag_b_s = ~operand_b + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_b_s = operand_b;
    end
  end

  // Result signs captured together with the operands at acceptance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (state_q == IDLE && start) begin
      neg_quot_q <= sa_s ^ sb_s;
      neg_rem_q  <= sa_s;
    end else begin
      neg_quot_q <= neg_quot_q;
      neg_rem_q  <= neg_rem_q;
    end
  end

  // FIX-cycle sign correction of product, quotient and remainder.
  always_comb begin
    prod_neg_s = ~acc_q[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1};
    res_hi_s   = acc_q[2*WIDTH-1:WIDTH];
    res_lo_s   = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_quot_q) begin
        res_lo_s = ~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        res_lo_s = acc_q[WIDTH-1:0];
      end
      if (neg_rem_q) begin
        res_hi_s = ~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        res_hi_s = acc_q[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (neg_quot_q) begin
        {res_hi_s, res_lo_s} = prod_neg_s;
      end else begin
        {res_hi_s, res_lo_s} = acc_q[2*WIDTH-1:0];
      end
    end
  end
`else
  logic unused_op0_s;

  // Unsigned-only build: the signedness bit of the op code is not used.
  assign unused_op0_s = op[0];

  // Operands are taken as raw unsigned magnitudes.
  always_comb begin
    mag_a_s = operand_a;
    mag_b_s = operand_b;
  end

  // FIX is a plain writeback: remainder/product-high to HI, quotient/product-low to LO.
  always_comb begin
    res_hi_s = acc_q[2*WIDTH-1:WIDTH];
    res_lo_s = acc_q[WIDTH-1:0];
  end
`endif

  // Next-state, datapath and output register update logic.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = is_div_op(op);
          if (is_div_op(op) && (operand_b == {WIDTH{1'b0}})) begin
            hi_d    = operand_a;
            lo_d    = {WIDTH{1'b1}};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (is_div_op(op)) begin
            acc_d   = {{(WIDTH+1){1'b0}}, mag_a_s};
            opnd_d  = mag_b_s;
            cnt_d   = {CNT_W{1'b0}};
            state_d = RUN;
          end else begin
            acc_d   = {{(WIDTH+1){1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
            cnt_d   = {CNT_W{1'b0}};
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc_s;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
          state_d = DONE;
        end
      end
      DONE: begin
        dbz_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs with asynchronous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      acc_q    <= {(2*WIDTH+1){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, randomized
// ops against an arithmetic reference model, and hand-written flush/reset
// sequences. Expectations follow the MULDIV_SIGNED_EN build option.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural operands.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    bit          sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    rdz = 1'b0;
    if (!o[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'd0) begin
      rdz = 1'b1;
      rh  = a;
      rl  = 32'hFFFF_FFFF;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end else begin
      rl = a / b;
      rh = a % b;
    end
  endtask

  // Issue one op from IDLE and wait (bounded) for done; edges counted from the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic with_flush,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                        output int n_edges, output int n_busy, output bit ok);
    rh = 32'd0; rl = 32'd0; rdz = 1'b0; ok = 1'b0; n_busy = 0;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; flush = with_flush;
    @(posedge clk);
    n_edges = 1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) n_busy++;
      if (done) begin
        ok = 1'b1; rh = hi; rl = lo; rdz = div_by_zero;
        break;
      end
      @(posedge clk);
      n_edges++;
      @(negedge clk);
    end
  endtask

  vec_t        vecs[11];
  logic [31:0] gh, gl, eh, el;
  logic        gdz, edz;
  int          ne, nb, dones;
  bit          ok;

  initial begin
    // Directed vectors (expected values derived by hand).
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
`ifdef MULDIV_SIGNED_EN
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
`else
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd3,         32'h0000_0002, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFEF, 32'd5,         32'h0000_0004, 32'h3333_332F, 1'b0};
    vecs[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
`endif
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};
    vecs[7]  = '{2'b11, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b10, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
    vecs[10] = '{2'b00, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};

    rst_b = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    operand_a = 32'd0; operand_b = 32'd0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("reset_hi",   {32'd0, hi}, 64'd0);
    chk("reset_lo",   {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, gh, gl, gdz, ne, nb, ok);
      chk($sformatf("vec%0d_done_seen", i), {63'd0, ok}, 64'd1);
      chk($sformatf("vec%0d_hi", i), {32'd0, gh}, {32'd0, vecs[i].exp_hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, gl}, {32'd0, vecs[i].exp_lo});
      chk($sformatf("vec%0d_dbz", i), {63'd0, gdz}, {63'd0, vecs[i].exp_dbz});
      chk($sformatf("vec%0d_latency", i), 64'(ne), vecs[i].exp_dbz ? 64'd1 : 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(nb), vecs[i].exp_dbz ? 64'd0 : 64'd33);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
      chk($sformatf("vec%0d_dbz_clear", i), {63'd0, div_by_zero}, 64'd0);
      last_hi = vecs[i].exp_hi;
      last_lo = vecs[i].exp_lo;
    end

    // Start and flush together in IDLE: start wins.
    run_op(2'b10, 32'd100, 32'd7, 1'b1, gh, gl, gdz, ne, nb, ok);
    chk("start_flush_done", {63'd0, ok}, 64'd1);
    chk("start_flush_lo", {32'd0, gl}, 64'd14);
    chk("start_flush_hi", {32'd0, gh}, 64'd2);
    last_hi = 32'd2; last_lo = 32'd14;

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ref_model(ro, ra, rb, eh, el, edz);
      run_op(ro, ra, rb, 1'b0, gh, gl, gdz, ne, nb, ok);
      chk($sformatf("rnd%0d_done_seen op=%0d a=%h b=%h", i, ro, ra, rb), {63'd0, ok}, 64'd1);
      chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), {32'd0, gh}, {32'd0, eh});
      chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), {32'd0, gl}, {32'd0, el});
      chk($sformatf("rnd%0d_dbz", i), {63'd0, gdz}, {63'd0, edz});
      last_hi = eh; last_lo = el;
    end

    // Flush mid-RUN at counter 10: no done, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_hi_kept", {32'd0, hi}, {32'd0, last_hi});
    chk("flush_lo_kept", {32'd0, lo}, {32'd0, last_lo});
    run_op(2'b10, 32'd9, 32'd3, 1'b0, gh, gl, gdz, ne, nb, ok);
    chk("after_flush_done", {63'd0, ok}, 64'd1);
    chk("after_flush_lo", {32'd0, gl}, 64'd3);
    chk("after_flush_hi", {32'd0, gh}, 64'd0);

    // Asynchronous reset mid-RUN, between edges.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // A second start while busy is ignored: exactly one done, from the first op.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clk);
    dones = 0; gh = 32'hDEAD_BEEF; gl = 32'hDEAD_BEEF;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        dones++; gh = hi; gl = lo;
      end
      if (i == 3) begin
        start = 1'b1; op = 2'b10; operand_a = 32'd50; operand_b = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_start_single_done", 64'(dones), 64'd1);
    chk("busy_start_hi", {32'd0, gh}, 64'd0);
    chk("busy_start_lo", {32'd0, gl}, 64'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
